// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared opcodes, state type and decode helper for exec_sequencer
package exec_pkg;

  localparam logic [4:0] OPC_RTYPE = 5'b00000;
  localparam logic [4:0] ALU_MUL   = 5'b00110;
  localparam logic [4:0] ALU_DIV   = 5'b00111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } md_state_t;

  function automatic logic is_md_op(input logic [4:0] opcode, input logic [4:0] aluop);
    return (opcode == OPC_RTYPE) && ((aluop == ALU_MUL) || (aluop == ALU_DIV));
  endfunction

endpackage

// File: rtl/exec_sequencer_if.sv
// rtl/exec_sequencer_if.sv - execute-stage instruction and mul/div result bundle
// master = pipeline side driving the instruction, slave = exec_sequencer.
interface exec_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic [4:0]       opcode;
  logic [4:0]       aluop;
  logic [4:0]       rd;
  logic [WIDTH-1:0] num_a;
  logic [WIDTH-1:0] num_b;
  logic             flush;
  logic             stall;
  logic             busy;
  logic             md_valid;
  logic [WIDTH-1:0] md_result;
  logic [4:0]       md_rd;
  logic             md_we;
  logic             md_exception;

  modport master (
    output in_valid, opcode, aluop, rd, num_a, num_b, flush,
    input  stall, busy, md_valid, md_result, md_rd, md_we, md_exception
  );

  modport slave (
    input  in_valid, opcode, aluop, rd, num_a, num_b, flush,
    output stall, busy, md_valid, md_result, md_rd, md_we, md_exception
  );

endinterface

// File: rtl/exec_sequencer_md_datapath.sv
// rtl/exec_sequencer_md_datapath.sv - radix-2 shift-add multiplier and restoring divider steps
// Divider registers are only built when EXEC_SEQ_DIV_EN is defined.
module md_datapath #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_step_mul,
  input  logic             i_step_div,
  input  logic             i_last,
  input  logic [WIDTH-1:0] i_num_a,
  input  logic [WIDTH-1:0] i_num_b,
  output logic [WIDTH-1:0] o_mul_result,
  output logic             o_mul_ovf,
  output logic [WIDTH-1:0] o_div_result,
  output logic             o_div_ovf
);

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] w_acc_next;

  // The multiplier's top bit weighs -2^(WIDTH-1), so the final step subtracts.
  always_comb begin
    w_acc_next = r_acc;
    if (r_mplier[0]) begin
      w_acc_next = i_last ? (r_acc - r_mcand) : (r_acc + r_mcand);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (i_load) begin
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{i_num_a[WIDTH-1]}}, i_num_a};
      r_mplier <= i_num_b;
    end else if (i_step_mul) begin
      r_acc    <= w_acc_next;
      r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
    end
  end

  // Results are taken from the step-next value so the FSM can capture on the last step.
  assign o_mul_result = w_acc_next[WIDTH-1:0];
  assign o_mul_ovf    = w_acc_next[2*WIDTH-1:WIDTH] != {WIDTH{w_acc_next[WIDTH-1]}};

`ifdef EXEC_SEQ_DIV_EN
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvsr;
  logic             r_neg;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? ((~v) + WIDTH'(1)) : v;
  endfunction

  always_comb begin
    w_trial = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_dvsr};
    if (!w_trial[WIDTH]) begin
      w_rem_next = w_trial[WIDTH-1:0];
      w_quo_next = {r_quo[WIDTH-2:0], 1'b1};
    end else begin
      w_rem_next = {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
      w_quo_next = {r_quo[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvsr <= '0;
      r_neg  <= 1'b0;
    end else if (i_load) begin
      r_rem  <= '0;
      r_quo  <= magnitude(i_num_a);
      r_dvsr <= magnitude(i_num_b);
      r_neg  <= i_num_a[WIDTH-1] ^ i_num_b[WIDTH-1];
    end else if (i_step_div) begin
      r_rem  <= w_rem_next;
      r_quo  <= w_quo_next;
    end
  end

  // A positive quotient with the top bit set only arises from MIN / -1.
  assign o_div_result = r_neg ? ((~w_quo_next) + WIDTH'(1)) : w_quo_next;
  assign o_div_ovf    = !r_neg && w_quo_next[WIDTH-1];
`else
  logic w_unused_div;
  assign w_unused_div = i_step_div;
  assign o_div_result = '0;
  assign o_div_ovf    = 1'b0;
`endif

endmodule

// File: rtl/exec_sequencer.sv
// rtl/exec_sequencer.sv - mul/div sequencing FSM beside the execute-stage ALU
// Iterative divider is present only when EXEC_SEQ_DIV_EN is defined; otherwise div reports an exception.
module exec_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  exec_sequencer_if.slave  bus
);
  import exec_pkg::*;

  md_state_t        r_state;
  md_state_t        w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_rd;
  logic [WIDTH-1:0] r_md_result;
  logic [4:0]       r_md_rd;
  logic             r_md_exc;

  logic             w_start;
  logic             w_start_div;
  logic             w_div_direct;
  logic             w_last;
  logic             w_busy;
  logic             w_stall;
  logic             w_md_valid;
  logic             w_load;
  logic             w_step_mul;
  logic             w_step_div;
  logic             w_capture;
  logic [WIDTH-1:0] w_cap_result;
  logic             w_cap_exc;
  logic [4:0]       w_cap_rd;
  logic [WIDTH-1:0] w_mul_result;
  logic             w_mul_ovf;
  logic [WIDTH-1:0] w_div_result;
  logic             w_div_ovf;

  // Reset is folded in so stall drops the instant reset is asserted.
  assign w_start     = reset && bus.in_valid && !bus.flush && (r_state == IDLE)
                       && is_md_op(bus.opcode, bus.aluop);
  assign w_start_div = w_start && (bus.aluop == ALU_DIV);
  assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef EXEC_SEQ_DIV_EN
  assign w_div_direct = w_start_div && (bus.num_b == '0);
`else
  assign w_div_direct = w_start_div;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          if (w_div_direct)     w_next = DONE;
          else if (w_start_div) w_next = DIV;
          else                  w_next = MUL;
        end
      end
      MUL, DIV: begin
        if (bus.flush)   w_next = IDLE;
        else if (w_last) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_busy       = (r_state == MUL) || (r_state == DIV);
    w_stall      = w_start || w_busy;
    w_md_valid   = (r_state == DONE) && !bus.flush;
    w_load       = w_start && !w_div_direct;
    w_step_mul   = (r_state == MUL);
    w_step_div   = (r_state == DIV);
    w_capture    = 1'b0;
    w_cap_result = '0;
    w_cap_exc    = 1'b0;
    w_cap_rd     = r_rd;
    if (w_div_direct) begin
      w_capture = 1'b1;
      w_cap_exc = 1'b1;
      w_cap_rd  = bus.rd;
    end else if (w_last && !bus.flush) begin
      if (r_state == MUL) begin
        w_capture    = 1'b1;
        w_cap_result = w_mul_result;
        w_cap_exc    = w_mul_ovf;
      end else if (r_state == DIV) begin
        w_capture    = 1'b1;
        w_cap_result = w_div_result;
        w_cap_exc    = w_div_ovf;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_load) begin
      r_cnt <= '0;
    end else if (w_busy) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Result tags are written on entry to DONE and then hold until the next DONE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rd        <= '0;
      r_md_result <= '0;
      r_md_rd     <= '0;
      r_md_exc    <= 1'b0;
    end else begin
      if (w_start) r_rd <= bus.rd;
      if (w_capture) begin
        r_md_result <= w_cap_result;
        r_md_rd     <= w_cap_rd;
        r_md_exc    <= w_cap_exc;
      end
    end
  end

  md_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clock        (clock),
    .reset        (reset),
    .i_load       (w_load),
    .i_step_mul   (w_step_mul),
    .i_step_div   (w_step_div),
    .i_last       (w_last),
    .i_num_a      (bus.num_a),
    .i_num_b      (bus.num_b),
    .o_mul_result (w_mul_result),
    .o_mul_ovf    (w_mul_ovf),
    .o_div_result (w_div_result),
    .o_div_ovf    (w_div_ovf)
  );

  assign bus.stall        = w_stall;
  assign bus.busy         = w_busy;
  assign bus.md_valid     = w_md_valid;
  assign bus.md_result    = r_md_result;
  assign bus.md_rd        = r_md_rd;
  assign bus.md_we        = w_md_valid && (r_md_rd != '0);
  assign bus.md_exception = r_md_exc;

endmodule

// File: tb/tb_exec_sequencer.sv
// tb/tb_exec_sequencer.sv - directed scoreboard bench for exec_sequencer
module tb_exec_sequencer;
  import exec_pkg::*;

  localparam int WIDTH = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  exec_sequencer_if #(.WIDTH(WIDTH)) bus ();

  exec_sequencer #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        exc;
    logic        we;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [4:0] aluop, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd);
    exp_t        e;
    longint      p;
    logic [63:0] pu;
    e.rd = rd;
    e.we = (rd != 5'd0);
    if (aluop == ALU_MUL) begin
      p        = longint'($signed(a)) * longint'($signed(b));
      pu       = p;
      e.result = pu[31:0];
      e.exc    = (pu[63:32] != {32{pu[31]}});
      e.lat    = 33;
    end else begin
`ifdef EXEC_SEQ_DIV_EN
      if (b == 32'd0) begin
        e.result = 32'd0; e.exc = 1'b1; e.lat = 1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.result = 32'h8000_0000; e.exc = 1'b1; e.lat = 33;
      end else begin
        e.result = $signed(a) / $signed(b); e.exc = 1'b0; e.lat = 33;
      end
`else
      e.result = 32'd0; e.exc = 1'b1; e.lat = 1;
`endif
    end
    return e;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, " stall"},    64'(bus.stall),        64'd0);
    check({tag, " busy"},     64'(bus.busy),         64'd0);
    check({tag, " md_valid"}, 64'(bus.md_valid),     64'd0);
    check({tag, " md_we"},    64'(bus.md_we),        64'd0);
    check({tag, " md_exc"},   64'(bus.md_exception), 64'd0);
    check({tag, " md_res"},   64'(bus.md_result),    64'd0);
    check({tag, " md_rd"},    64'(bus.md_rd),        64'd0);
  endtask

  // Presents an md op, checks stall/busy each cycle, compares the popped entry at md_valid.
  // Returns 1 ns after the DONE cycle's falling edge, so a following call starts at cycle 34.
  task automatic do_op(input logic [4:0] aluop, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input string tag);
    exp_t e;
    exp_t got;
    bit   seen;
    e = model(aluop, a, b, rd);
    @(negedge clock);
    bus.in_valid = 1'b1; bus.opcode = OPC_RTYPE; bus.aluop = aluop;
    bus.rd = rd; bus.num_a = a; bus.num_b = b; bus.flush = 1'b0;
    sb.push_back(e);
    seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (bus.md_valid === 1'b1) begin
        seen = 1'b1;
        check({tag, " latency"}, 64'(c), 64'(e.lat));
        check({tag, " sb nonempty"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          got = sb.pop_front();
          check({tag, " result"}, 64'(bus.md_result),    64'(got.result));
          check({tag, " rd"},     64'(bus.md_rd),        64'(got.rd));
          check({tag, " we"},     64'(bus.md_we),        64'(got.we));
          check({tag, " exc"},    64'(bus.md_exception), 64'(got.exc));
        end
        check({tag, " done stall"}, 64'(bus.stall), 64'd0);
        break;
      end
      check({tag, " stall"}, 64'(bus.stall), 64'd1);
      check({tag, " busy"},  64'(bus.busy),  64'(c != 0));
      @(negedge clock);
    end
    check({tag, " md_valid seen"}, 64'(seen), 64'd1);
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      #1;
      check({tag, " stall"},    64'(bus.stall),    64'd0);
      check({tag, " md_valid"}, 64'(bus.md_valid), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [4:0] flush_op;
    bus.in_valid = 1'b0; bus.opcode = OPC_RTYPE; bus.aluop = 5'd0; bus.rd = 5'd0;
    bus.num_a = '0; bus.num_b = '0; bus.flush = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    #1 check_zero("reset idle");
    bus.in_valid = 1'b1; bus.aluop = ALU_MUL; bus.num_a = 32'd3; bus.num_b = 32'd4;
    #1 check_zero("reset md op");
    bus.in_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;

    do_op(ALU_MUL, 32'd7, 32'hFFFF_FFFA, 5'd3, "mul 7x-6");
    check("mul 7x-6 const", 64'(bus.md_result), 64'h0000_0000_FFFF_FFD6);
    @(negedge clock);
    bus.in_valid = 1'b0;
    #1;
    check("hold md_valid", 64'(bus.md_valid),     64'd0);
    check("hold result",   64'(bus.md_result),    64'h0000_0000_FFFF_FFD6);
    check("hold rd",       64'(bus.md_rd),        64'd3);
    check("hold we",       64'(bus.md_we),        64'd0);
    check("hold exc",      64'(bus.md_exception), 64'd0);

    do_op(ALU_MUL, 32'h0001_0000, 32'h0001_0000, 5'd5,  "mul ovf");
    do_op(ALU_MUL, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7,  "mul min*-1");
    do_op(ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  "mul -1*-1");
    do_op(ALU_MUL, 32'h8000_0000, 32'h8000_0000, 5'd31, "mul min*min");
    do_op(ALU_DIV, 32'hFFFF_FF9C, 32'd7,         5'd0,  "div -100/7");
    do_op(ALU_DIV, 32'd5,         32'd0,         5'd4,  "div by zero");
    do_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9,  "div min/-1");
    do_op(ALU_DIV, 32'd10,        32'd2,         5'd2,  "div 10/2");
    do_op(ALU_DIV, 32'd7,         32'hFFFF_FF9C, 5'd6,  "div 7/-100");
    do_op(ALU_DIV, 32'h8000_0000, 32'd1,         5'd8,  "div min/1");

    @(negedge clock);
    bus.in_valid = 1'b1; bus.aluop = 5'd0;
    idle_cycles(5, "add");
    bus.in_valid = 1'b0; bus.aluop = ALU_MUL;
    idle_cycles(3, "nop mul");
    bus.in_valid = 1'b1; bus.flush = 1'b1;
    idle_cycles(3, "flush idle");
    bus.flush = 1'b0; bus.in_valid = 1'b0;

`ifdef EXEC_SEQ_DIV_EN
    flush_op = ALU_DIV;
`else
    flush_op = ALU_MUL;
`endif
    @(negedge clock);
    bus.in_valid = 1'b1; bus.aluop = flush_op; bus.rd = 5'd11;
    bus.num_a = 32'hFFFF_FF9C; bus.num_b = 32'd7;
    repeat (5) @(negedge clock);
    bus.flush = 1'b1;
    #1 check("flush cyc5 md_valid", 64'(bus.md_valid), 64'd0);
    @(negedge clock);
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    #1;
    check("flush busy",  64'(bus.busy),  64'd0);
    check("flush stall", 64'(bus.stall), 64'd0);
    idle_cycles(40, "post flush");
    do_op(ALU_MUL, 32'd1234, 32'hFFFF_E9D2, 5'd12, "mul after flush");

    @(negedge clock);
    bus.in_valid = 1'b1; bus.aluop = ALU_MUL; bus.rd = 5'd6; bus.num_a = 32'd3; bus.num_b = 32'd4;
    repeat (10) @(negedge clock);
    #1 check("pre-reset busy", 64'(bus.busy), 64'd1);
    #1 reset = 1'b0;
    #1 check_zero("async reset");
    bus.aluop = 5'd0;
    @(negedge clock);
    reset = 1'b1;
    #1 check("release stall", 64'(bus.stall), 64'd0);
    idle_cycles(40, "post reset");

    check("scoreboard empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
